window_3x3_gen: RTL

- Streaming 3x3 neighbourhood generator that sits directly upstream of the edge-detection stage.
- Accepts one 8-bit grayscale pixel per handshake in raster order.
- Emits one full 3x3 window per pixel position, taps out0..out8, which drive the edge detector's in0..in8.
- Buffers two image rows internally, replicates the centre pixel for out-of-image taps, and flushes the tail of each frame without further input.

---
 rtl/window_3x3_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two circular line buffers feed a 3x3
// register array; border taps are replaced by the centre pixel at the output stage.
module window_3x3_gen #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out0,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7,
    output logic [DW-1:0] out8,
    output logic          out_first,
    output logic          out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] ic_c, oc_c, wc, ptr;
    logic [RW-1:0] ic_r, oc_r, wr;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] win [3][3];
    logic [DW-1:0] tap [9];
    logic [DW-1:0] o_q [9];
    logic [DW-1:0] new_px;
    logic          w_valid, ov_q, of_q, ol_q;
    logic          adv, accept, produce, shift, in_last, flush_pend;

    assign adv        = !ov_q || out_ready;
    assign in_last    = (ic_r == R_MAX) && (ic_c == C_MAX);
    // Output counter wraps to (0,0) once the final centre has been generated.
    assign flush_pend = (oc_r != '0) || (oc_c != '0);
    assign new_px     = accept ? in_pixel : '0;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        produce  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept && ic_r == RW'(1) && ic_c == '0) state_d = RUN;
            end
            RUN: begin
                in_ready = adv;
                accept   = in_valid && adv;
                produce  = accept;
                if (accept && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                produce = adv && flush_pend;
                if (ov_q && out_ready && ol_q) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        shift = accept || produce;
    end

    always_comb begin
        for (int unsigned dr = 0; dr < 3; dr++) begin
            for (int unsigned dc = 0; dc < 3; dc++) begin
                if ((dr == 0 && wr == '0) || (dr == 2 && wr == R_MAX) ||
                    (dc == 0 && wc == '0) || (dc == 2 && wc == C_MAX))
                    tap[dr*3+dc] = win[1][1];
                else
                    tap[dr*3+dc] = win[dr][dc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            ic_c    <= '0;
            ic_r    <= '0;
            oc_c    <= '0;
            oc_r    <= '0;
            ptr     <= '0;
            w_valid <= 1'b0;
            ov_q    <= 1'b0;
            of_q    <= 1'b0;
            ol_q    <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) o_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (ic_c == C_MAX) begin
                    ic_c <= '0;
                    ic_r <= (ic_r == R_MAX) ? '0 : ic_r + RW'(1);
                end else begin
                    ic_c <= ic_c + CW'(1);
                end
            end
            if (produce) begin
                wr <= oc_r;
                wc <= oc_c;
                if (oc_c == C_MAX) begin
                    oc_c <= '0;
                    oc_r <= (oc_r == R_MAX) ? '0 : oc_r + RW'(1);
                end else begin
                    oc_c <= oc_c + CW'(1);
                end
            end
            if (shift) ptr <= (ptr == C_MAX) ? '0 : ptr + CW'(1);
            if (adv) begin
                w_valid <= produce;
                ov_q    <= w_valid;
                of_q    <= w_valid && wr == '0 && wc == '0;
                ol_q    <= w_valid && wr == R_MAX && wc == C_MAX;
                if (w_valid)
                    for (int unsigned i = 0; i < 9; i++) o_q[i] <= tap[i];
            end
        end
    end

    // Column wrap is left to the output masking; the shift chain runs across rows.
    always_ff @(posedge clk) begin
        if (shift) begin
            lb1[ptr] <= new_px;
            lb0[ptr] <= lb1[ptr];
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[ptr];
            win[1][2] <= lb1[ptr];
            win[2][2] <= new_px;
        end
    end

    assign out_valid = ov_q;
    assign out_first = of_q;
    assign out_last  = ol_q;
    assign out0 = o_q[0];
    assign out1 = o_q[1];
    assign out2 = o_q[2];
    assign out3 = o_q[3];
    assign out4 = o_q[4];
    assign out5 = o_q[5];
    assign out6 = o_q[6];
    assign out7 = o_q[7];
    assign out8 = o_q[8];
endmodule
